// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - cpustate encodings and loader FSM states (RAM_LOADER_READBACK_EN adds S_VERIFY)
package cpu_pkg;

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_RUN   = 2'b01;
  localparam logic [1:0] CS_LOAD  = 2'b10;
  localparam logic [1:0] CS_CHECK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SYNC,
    S_WRITE,
`ifdef RAM_LOADER_READBACK_EN
    S_VERIFY,
`endif
    S_RELEASE
  } loader_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer plus counting debouncer for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // cnt tracks how many consecutive samples disagree with the accepted level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      key_out <= 1'b1;
    end else if (sync2 == key_out) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt     <= '0;
      key_out <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - pushbutton-driven RAM word loader; RAM_LOADER_READBACK_EN adds a readback check
module ram_loader
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        A1,
  input  logic [7:0]  D,
  input  logic [1:0]  cpustate,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        write,
  output logic        busy,
  output logic [7:0]  count,
  output logic        wrapped
`ifdef RAM_LOADER_READBACK_EN
  ,
  output logic        read,
  input  logic [7:0]  rdata,
  output logic        err
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loader_state_e state, nxt;
  logic          key_db;
  logic          key_prev;
  logic          press;
  logic [PW-1:0] ptr;
  logic          load_mode;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk     (clk),
    .rst     (rst),
    .key_in  (A1),
    .key_out (key_db)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_prev <= 1'b1;
    else      key_prev <= key_db;
  end

  assign press     = key_prev & ~key_db;
  assign load_mode = (cpustate == CS_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!load_mode) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    nxt = S_ARMED;
        S_ARMED:   if (press) nxt = S_SYNC;
        S_SYNC:    nxt = S_WRITE;
`ifdef RAM_LOADER_READBACK_EN
        S_WRITE:   nxt = S_VERIFY;
        S_VERIFY:  nxt = S_RELEASE;
`else
        S_WRITE:   nxt = S_RELEASE;
`endif
        S_RELEASE: if (key_db) nxt = S_ARMED;
        default:   nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are gated by load_mode so leaving LOAD kills them in the same cycle
  always_comb begin
    write = (state == S_WRITE) && load_mode;
`ifdef RAM_LOADER_READBACK_EN
    read  = (state == S_VERIFY) && load_mode;
    busy  = (state == S_SYNC) || (state == S_WRITE) || (state == S_VERIFY);
`else
    busy  = (state == S_SYNC) || (state == S_WRITE);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      addr     <= '0;
      data_out <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
    end else begin
      if (state == S_IDLE && nxt == S_ARMED) begin
        ptr     <= '0;
        count   <= '0;
        wrapped <= 1'b0;
      end
      if (state == S_SYNC && nxt == S_WRITE) begin
        data_out <= D;
        addr     <= 16'(ptr);
      end
      if (write) begin
        ptr   <= ptr + PW'(1);
        count <= (count == 8'hFF) ? count : count + 8'd1;
        if (ptr == PW'(DEPTH - 1)) wrapped <= 1'b1;
      end
    end
  end

`ifdef RAM_LOADER_READBACK_EN
  // RAM returns read data one cycle after the read strobe
  logic verify_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      verify_pending <= 1'b0;
      err            <= 1'b0;
    end else begin
      verify_pending <= read;
      if (state == S_IDLE && nxt == S_ARMED)
        err <= 1'b0;
      else if (verify_pending && load_mode && (rdata != data_out))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable clk samples required to accept an A1 level change.
REQ-002 Parameter DEPTH, default 256, is the number of loadable RAM words; it is a power of two, 2..256.
REQ-003 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 A1  input  1  raw load pushbutton, active-low (0 = pressed), asynchronous to clk.
REQ-006 D  input  8  switch data word to be written.
REQ-007 cpustate  input  2  CPU mode: 00 idle, 01 run, 10 load, 11 check.
REQ-008 addr  output  16  RAM write address, zero-extended from the internal pointer.
REQ-009 data_out  output  8  RAM write data.
REQ-010 write  output  1  one-cycle RAM write strobe.
REQ-011 busy  output  1  high while a write sequence is in progress (states SYNC..WRITE).
REQ-012 count  output  8  number of words written since LOAD entry, saturating at 255.
REQ-013 wrapped  output  1  sticky; the pointer has wrapped from DEPTH-1 to 0 during the current LOAD session.

Function
REQ-014 A1 shall pass through a 2-flop synchronizer, then a debouncer that updates its output only after DEBOUNCE_CYCLES identical consecutive samples.
REQ-015 A press event shall be a 1->0 transition of the debounced A1 and shall be one clk cycle wide.
REQ-016 The FSM shall have states IDLE, ARMED, SYNC, WRITE and RELEASE.
REQ-017 IDLE -> ARMED when cpustate == 10; on this transition, pointer, count and wrapped clear to 0.
REQ-018 ARMED -> SYNC on a press event; in SYNC, D is captured into data_out and the pointer drives addr.
REQ-019 SYNC -> WRITE after exactly 1 cycle; write is high for exactly the one cycle spent in WRITE.
REQ-020 WRITE -> RELEASE; the pointer increments modulo DEPTH and count increments, saturating at 255.
REQ-021 When the pointer increments from DEPTH-1 to 0, wrapped shall be set.
REQ-022 RELEASE -> ARMED only after the debounced A1 returns to 1, so a held key produces exactly one write.
REQ-023 Latency from press event to write high shall be 2 cycles.
REQ-024 In any state, cpustate != 10 shall force the next state to IDLE and write to 0. A pending, not-yet-issued write is dropped. Pointer, count and wrapped hold their values.
REQ-025 In IDLE, write is 0. addr and data_out hold their last values.
REQ-026 A press event in any state other than ARMED shall be ignored.

Reset
REQ-027 While rst == 0: FSM = IDLE; addr = 0; data_out = 0; write = 0; busy = 0; count = 0; wrapped = 0; synchronizer and debouncer outputs = 1 (released); debounce counter = 0.
REQ-028 Reset asserted mid-sequence shall abort the sequence immediately, with no write strobe.

Configuration
REQ-029 Macro RAM_LOADER_READBACK_EN adds a readback check, inserted between WRITE and RELEASE.
REQ-030 With the macro defined:
  - ports read (output, 1) and rdata (input, 8) exist.
  - a VERIFY state holds read high for 1 cycle, with addr unchanged.
  - the next cycle samples rdata; a mismatch with data_out sets sticky output err (cleared on LOAD entry and reset).
  - the press-to-write latency is unchanged.
REQ-031 Without the macro: no read, rdata, err or VERIFY; WRITE goes directly to RELEASE.

Structure
REQ-032 The shared package cpu_pkg shall hold the cpustate encodings (CS_IDLE, CS_RUN, CS_LOAD, CS_CHECK) and the loader FSM state enumeration.
REQ-033 The synchronizer and debouncer shall be one sub-module, key_debounce (clk, rst, key_in, key_out), so they can be reused for other keys.

Verification
REQ-034 Reset then LOAD: cpustate = 10, D = 8'hA5, A1 pulsed low for 10 cycles -> exactly one write, addr = 0, data_out = A5, count = 1, 2 cycles after the debounced press.
REQ-035 Bounce: A1 toggles every cycle for 3 cycles, then stays low for 10 -> exactly one write.
REQ-036 Wrap: with DEPTH = 4, five presses with D = 1..5 -> writes at addr 0,1,2,3,0; wrapped = 1 after the 4th; count = 5.
REQ-037 Abort: cpustate changes 10 -> 01 in the SYNC cycle -> no write, FSM = IDLE; re-entering LOAD gives count = 0 and addr = 0.
REQ-038 Async reset: rst low mid-WRITE -> write = 0 within the same cycle and all outputs at reset values.
REQ-039 With RAM_LOADER_READBACK_EN: rdata returns D XOR 8'h01 -> err = 1; a correct rdata leaves err = 0.
